// File: rtl/riscv_pkg.sv
// Shared RV32I controller definitions: FSM state encoding, major opcodes and the NOP word.
package riscv_pkg;

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4,
      HALT   = 3'd5
   } state_e;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_OP     = 7'b0110011;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   // True for the major opcodes this controller knows how to sequence.
   function automatic logic is_known_op(input logic [6:0] op);
      logic known_s;
      case (op)
         OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
         OP_LOAD, OP_STORE, OP_IMM, OP_OP: known_s = 1'b1;
         default:                          known_s = 1'b0;
      endcase
      return known_s;
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts memory wait cycles; expired fires on the cycle that would be the TIMEOUT-th wait.
module mem_wait_timer #(
   parameter int unsigned TIMEOUT = 32'd16
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   input  logic count,
   output logic expired
);

   localparam logic [15:0] LIMIT = 16'(TIMEOUT - 32'd1);

   logic [15:0] count_r;

   // Wait-cycle counter, cleared on every controller state change.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_r <= 16'd0;
      end else if (clear) begin
         count_r <= 16'd0;
      end else if (count) begin
         count_r <= count_r + 16'd1;
      end else begin
         count_r <= count_r;
      end
   end

   assign expired = count && (count_r == LIMIT);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM: sequences fetch, decode, execute, memory and writeback,
// owns the PC and IR, and halts on illegal opcodes, misaligned targets or memory timeouts.
module multicycle_ctrl
   import riscv_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned TIMEOUT  = 32'd16
) (
   input  logic        clk,
   input  logic        reset_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   input  logic [31:0] imm,
   input  logic [31:0] alu_result,
   input  logic        br_taken,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   input  logic        dmem_ack,
   output logic        rf_we,
   output logic [31:0] pc,
   output logic        instret,
   output logic        halt
);

   state_e      state_r, state_nxt_s;
   logic [31:0] pc_r, instr_r, npc_r, dmem_addr_r;
   logic        imem_req_r, dmem_req_r, dmem_we_r, rf_we_r, instret_r, halt_r;
   logic [6:0]  opcode_s;
   logic [31:0] pc_plus4_s, pc_imm_s, jalr_tgt_s, pc_nxt_s, npc_nxt_s;
   logic        imem_fire_s, dmem_fire_s, wait_s, expired_s, clear_s;
   logic        load_ir_s, pc_wr_s, retire_s, latch_daddr_s;

   assign opcode_s    = instr_r[6:0];
   assign pc_plus4_s  = pc_r + 32'd4;
   assign pc_imm_s    = pc_r + imm;
   assign jalr_tgt_s  = {alu_result[31:1], 1'b0};
   // Acks only count while the matching request is actually on the bus.
   assign imem_fire_s = imem_req_r && imem_ack;
   assign dmem_fire_s = dmem_req_r && dmem_ack;
   assign wait_s      = ((state_r == FETCH) && imem_req_r && !imem_ack) ||
                        ((state_r == MEM)   && dmem_req_r && !dmem_ack);
   assign clear_s     = (state_nxt_s != state_r);

   mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (clear_s),
      .count   (wait_s),
      .expired (expired_s)
   );

   // Next-state and PC/IR update decisions.
   always_comb begin
      state_nxt_s   = state_r;
      load_ir_s     = 1'b0;
      pc_wr_s       = 1'b0;
      pc_nxt_s      = pc_r;
      retire_s      = 1'b0;
      latch_daddr_s = 1'b0;
      npc_nxt_s     = pc_plus4_s;
      case (state_r)
         FETCH: begin
            if (imem_fire_s) begin
               load_ir_s   = 1'b1;
               state_nxt_s = DECODE;
            end else if (expired_s) begin
               state_nxt_s = HALT;
            end else begin
               state_nxt_s = FETCH;
            end
         end
         DECODE: begin
            if (is_known_op(opcode_s)) begin
               state_nxt_s = EXEC;
            end else begin
               state_nxt_s = HALT;
            end
         end
         EXEC: begin
            case (opcode_s)
               OP_LOAD, OP_STORE: begin
                  latch_daddr_s = 1'b1;
                  state_nxt_s   = MEM;
               end
               OP_BRANCH: begin
                  if (br_taken && pc_imm_s[1]) begin
                     state_nxt_s = HALT;
                  end else begin
                     pc_wr_s     = 1'b1;
                     pc_nxt_s    = br_taken ? pc_imm_s : pc_plus4_s;
                     retire_s    = 1'b1;
                     state_nxt_s = FETCH;
                  end
               end
               // Jump targets are checked here so a bad target never reaches WB.
               OP_JAL: begin
                  npc_nxt_s   = pc_imm_s;
                  state_nxt_s = pc_imm_s[1] ? HALT : WB;
               end
               OP_JALR: begin
                  npc_nxt_s   = jalr_tgt_s;
                  state_nxt_s = jalr_tgt_s[1] ? HALT : WB;
               end
               default: begin
                  state_nxt_s = WB;
               end
            endcase
         end
         MEM: begin
            if (dmem_fire_s) begin
               if (opcode_s == OP_STORE) begin
                  pc_wr_s     = 1'b1;
                  pc_nxt_s    = pc_plus4_s;
                  retire_s    = 1'b1;
                  state_nxt_s = FETCH;
               end else begin
                  state_nxt_s = WB;
               end
            end else if (expired_s) begin
               state_nxt_s = HALT;
            end else begin
               state_nxt_s = MEM;
            end
         end
         WB: begin
            pc_wr_s     = 1'b1;
            pc_nxt_s    = npc_r;
            retire_s    = 1'b1;
            state_nxt_s = FETCH;
         end
         HALT: begin
            state_nxt_s = HALT;
         end
         default: begin
            state_nxt_s = HALT;
         end
      endcase
   end

   // State register and registered control outputs, decoded from the next state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r    <= FETCH;
         imem_req_r <= 1'b0;
         dmem_req_r <= 1'b0;
         dmem_we_r  <= 1'b0;
         rf_we_r    <= 1'b0;
         instret_r  <= 1'b0;
         halt_r     <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         imem_req_r <= (state_nxt_s == FETCH);
         dmem_req_r <= (state_nxt_s == MEM);
         dmem_we_r  <= (state_nxt_s == MEM) && (opcode_s == OP_STORE);
         rf_we_r    <= (state_nxt_s == WB);
         instret_r  <= retire_s;
         halt_r     <= (state_nxt_s == HALT);
      end
   end

   // PC, IR, pending next-PC and data address registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pc_r        <= RESET_PC;
         instr_r     <= NOP_INSTR;
         npc_r       <= RESET_PC;
         dmem_addr_r <= 32'h0000_0000;
      end else begin
         if (load_ir_s)          instr_r     <= imem_rdata;
         if (pc_wr_s)            pc_r        <= pc_nxt_s;
         if (state_r == EXEC)    npc_r       <= npc_nxt_s;
         if (latch_daddr_s)      dmem_addr_r <= alu_result;
      end
   end

   assign imem_req  = imem_req_r;
   assign imem_addr = pc_r;
   assign instr     = instr_r;
   assign dmem_req  = dmem_req_r;
   assign dmem_we   = dmem_we_r;
   assign dmem_addr = dmem_addr_r;
   assign rf_we     = rf_we_r;
   assign pc        = pc_r;
   assign instret   = instret_r;
   assign halt      = halt_r;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: bench-side memory/datapath responder plus expected-PC queue.
module tb_multicycle_ctrl;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int          TMO      = 16;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   logic        clk, reset_n;
   logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, rf_we, instret, halt, br_taken;
   logic [31:0] imem_addr, imem_rdata, instr, imm, alu_result, dmem_addr, pc;

   int          checks   = 0;
   int          failures = 0;
   logic [31:0] exp_q[$];
   logic [31:0] model_pc;

   // Trace of the most recent run_instr call.
   int          tr_ret_cyc, tr_rfwe_cyc, tr_rfwe_cnt, tr_dreq_run, tr_halt_cyc;
   logic [31:0] tr_iaddr, tr_daddr;
   logic        tr_dwe, tr_dstable, tr_excl_ok, tr_tmo;

   multicycle_ctrl #(.RESET_PC(RESET_PC), .TIMEOUT(TMO)) dut (
      .clk(clk), .reset_n(reset_n),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .instr(instr), .imm(imm), .alu_result(alu_result), .br_taken(br_taken),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_ack(dmem_ack),
      .rf_we(rf_we), .pc(pc), .instret(instret), .halt(halt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic apply_reset();
      reset_n = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; imem_rdata = 32'd0;
      imm = 32'd0; alu_result = 32'd0; br_taken = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      model_pc = RESET_PC;
      exp_q.delete();
   endtask

   // Plays memory and datapath for one instruction; cycle 1 is the call's entry negedge.
   task automatic run_instr(input logic [31:0] word, input logic [31:0] imm_v,
                            input logic [31:0] alu_v, input logic br_v,
                            input int iwait, input int dwait, input int max_cyc);
      int ireq = 0;
      int dreq = 0;
      tr_ret_cyc = 0; tr_rfwe_cyc = 0; tr_rfwe_cnt = 0; tr_dreq_run = 0; tr_halt_cyc = 0;
      tr_iaddr = 32'hxxxx_xxxx; tr_daddr = 32'hxxxx_xxxx; tr_dwe = 1'bx;
      tr_dstable = 1'b1; tr_excl_ok = 1'b1; tr_tmo = 1'b0;
      imm = imm_v; alu_result = alu_v; br_taken = br_v;
      for (int c = 1; c <= max_cyc; c++) begin
         if (c > 1 && instret) begin tr_ret_cyc = c; break; end
         if (halt) begin tr_halt_cyc = c; break; end
         if (imem_req && dmem_req) tr_excl_ok = 1'b0;
         if (rf_we) begin tr_rfwe_cnt++; tr_rfwe_cyc = c; end
         if (imem_req) begin
            ireq++;
            if (ireq == 1) tr_iaddr = imem_addr;
            imem_ack   = (ireq > iwait);
            imem_rdata = (ireq > iwait) ? word : 32'hDEAD_BEEF;
         end else begin
            imem_ack = 1'b0;
         end
         if (dmem_req) begin
            dreq++;
            if (dreq == 1) begin
               tr_daddr = dmem_addr; tr_dwe = dmem_we;
            end else if (dmem_addr !== tr_daddr || dmem_we !== tr_dwe) begin
               tr_dstable = 1'b0;
            end
            dmem_ack   = (dreq > dwait);
            alu_result = ~alu_v;
         end else begin
            dmem_ack   = 1'b0;
            alu_result = alu_v;
         end
         tr_dreq_run = dreq;
         @(negedge clk);
         if (c == max_cyc) tr_tmo = 1'b1;
      end
      imem_ack = 1'b0; dmem_ack = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; imem_ack = 1'b1; dmem_ack = 1'b1; imem_rdata = 32'h0050_0093;
      imm = 32'd0; alu_result = 32'd0; br_taken = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (pc !== RESET_PC) begin failures++; $display("FAIL reset_pc: got %h want %h", pc, RESET_PC); end
      checks++; if (instr !== NOP) begin failures++; $display("FAIL reset_ir: got %h want %h", instr, NOP); end
      checks++;
      if ({imem_req, dmem_req, dmem_we, rf_we, instret, halt} !== 6'b000000) begin
         failures++; $display("FAIL reset_ctrl: got %b want 000000", {imem_req, dmem_req, dmem_we, rf_we, instret, halt});
      end
      imem_ack = 1'b0; dmem_ack = 1'b0;
      reset_n = 1'b1;
      @(negedge clk);
      checks++; if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
         failures++; $display("FAIL reset_first_req: got req=%b addr=%h want req=1 addr=%h", imem_req, imem_addr, RESET_PC);
      end
      model_pc = RESET_PC;
      exp_q.delete();
   endtask

   task automatic test_alu();
      logic [31:0] exp_pc;
      exp_q.push_back(model_pc + 32'd4);
      run_instr(32'h0050_0093, 32'd5, 32'd5, 1'b0, 0, 0, 20);
      checks++; if (tr_iaddr !== model_pc) begin failures++; $display("FAIL alu_fetch_addr: got %h want %h", tr_iaddr, model_pc); end
      checks++; if (instr !== 32'h0050_0093) begin failures++; $display("FAIL alu_ir: got %h want %h", instr, 32'h0050_0093); end
      checks++; if (tr_rfwe_cyc !== 4 || tr_rfwe_cnt !== 1) begin
         failures++; $display("FAIL alu_rf_we: got cyc=%0d cnt=%0d want cyc=4 cnt=1", tr_rfwe_cyc, tr_rfwe_cnt);
      end
      checks++; if (tr_ret_cyc !== 5) begin failures++; $display("FAIL alu_retire_cycle: got %0d want 5", tr_ret_cyc); end
      exp_pc = exp_q.pop_front();
      checks++; if (pc !== exp_pc) begin failures++; $display("FAIL alu_pc: got %h want %h", pc, exp_pc); end
      model_pc = exp_pc;
      // Same class of instruction with two fetch wait states.
      exp_q.push_back(model_pc + 32'd4);
      run_instr(32'h1234_5137, 32'h1234_5000, 32'h1234_5000, 1'b0, 2, 0, 20);
      checks++; if (tr_ret_cyc !== 7) begin failures++; $display("FAIL lui_wait_retire_cycle: got %0d want 7", tr_ret_cyc); end
      exp_pc = exp_q.pop_front();
      checks++; if (pc !== exp_pc) begin failures++; $display("FAIL lui_pc: got %h want %h", pc, exp_pc); end
      model_pc = exp_pc;
   endtask

   task automatic test_load();
      logic [31:0] exp_pc;
      exp_q.push_back(model_pc + 32'd4);
      run_instr(32'h0000_A183, 32'd0, 32'h0000_0100, 1'b0, 0, 3, 30);
      checks++; if (tr_dreq_run !== 4) begin failures++; $display("FAIL load_dreq_len: got %0d want 4", tr_dreq_run); end
      checks++; if (tr_daddr !== 32'h0000_0100 || tr_dstable !== 1'b1 || tr_dwe !== 1'b0) begin
         failures++; $display("FAIL load_daddr: got addr=%h stable=%b we=%b want addr=00000100 stable=1 we=0", tr_daddr, tr_dstable, tr_dwe);
      end
      checks++; if (tr_rfwe_cyc !== 8 || tr_rfwe_cnt !== 1) begin
         failures++; $display("FAIL load_rf_we: got cyc=%0d cnt=%0d want cyc=8 cnt=1", tr_rfwe_cyc, tr_rfwe_cnt);
      end
      checks++; if (tr_ret_cyc !== 9 || tr_excl_ok !== 1'b1) begin
         failures++; $display("FAIL load_retire: got cyc=%0d excl=%b want cyc=9 excl=1", tr_ret_cyc, tr_excl_ok);
      end
      exp_pc = exp_q.pop_front();
      checks++; if (pc !== exp_pc) begin failures++; $display("FAIL load_pc: got %h want %h", pc, exp_pc); end
      model_pc = exp_pc;
   endtask

   task automatic test_store();
      logic [31:0] exp_pc;
      exp_q.push_back(model_pc + 32'd4);
      run_instr(32'h0020_A023, 32'd0, 32'h0000_0204, 1'b0, 0, 0, 20);
      checks++; if (tr_dreq_run !== 1 || tr_dwe !== 1'b1 || tr_daddr !== 32'h0000_0204) begin
         failures++; $display("FAIL store_dmem: got len=%0d we=%b addr=%h want len=1 we=1 addr=00000204", tr_dreq_run, tr_dwe, tr_daddr);
      end
      checks++; if (tr_rfwe_cnt !== 0 || tr_ret_cyc !== 5) begin
         failures++; $display("FAIL store_retire: got rf_we_cnt=%0d cyc=%0d want 0 and 5", tr_rfwe_cnt, tr_ret_cyc);
      end
      exp_pc = exp_q.pop_front();
      checks++; if (pc !== exp_pc) begin failures++; $display("FAIL store_pc: got %h want %h", pc, exp_pc); end
      model_pc = exp_pc;
   endtask

   task automatic test_jal();
      logic [31:0] exp_pc;
      exp_q.push_back(model_pc + 32'h0000_0010);
      run_instr(32'h0100_00EF, 32'h0000_0010, 32'd0, 1'b0, 0, 0, 20);
      checks++; if (tr_rfwe_cyc !== 4 || tr_ret_cyc !== 5) begin
         failures++; $display("FAIL jal_timing: got rf_we=%0d ret=%0d want 4 and 5", tr_rfwe_cyc, tr_ret_cyc);
      end
      exp_pc = exp_q.pop_front();
      checks++; if (pc !== exp_pc) begin failures++; $display("FAIL jal_pc: got %h want %h", pc, exp_pc); end
      model_pc = exp_pc;
   endtask

   task automatic test_branch();
      logic [31:0] exp_pc;
      exp_q.push_back(model_pc + 32'hFFFF_FFF8);
      run_instr(32'hFE00_0CE3, 32'hFFFF_FFF8, 32'd0, 1'b1, 0, 0, 20);
      checks++; if (tr_rfwe_cnt !== 0 || tr_ret_cyc !== 4) begin
         failures++; $display("FAIL beq_taken: got rf_we_cnt=%0d ret=%0d want 0 and 4", tr_rfwe_cnt, tr_ret_cyc);
      end
      exp_pc = exp_q.pop_front();
      checks++; if (pc !== exp_pc) begin failures++; $display("FAIL beq_taken_pc: got %h want %h", pc, exp_pc); end
      model_pc = exp_pc;
      exp_q.push_back(model_pc + 32'd4);
      run_instr(32'hFE00_0CE3, 32'hFFFF_FFF8, 32'd0, 1'b0, 0, 0, 20);
      exp_pc = exp_q.pop_front();
      checks++; if (pc !== exp_pc || tr_ret_cyc !== 4) begin
         failures++; $display("FAIL beq_not_taken: got pc=%h ret=%0d want pc=%h ret=4", pc, tr_ret_cyc, exp_pc);
      end
      model_pc = exp_pc;
   endtask

   task automatic test_jalr();
      logic [31:0] exp_pc;
      logic [31:0] alu_v = 32'h0000_0045;
      exp_q.push_back(alu_v & 32'hFFFF_FFFE);
      run_instr(32'h0000_80E7, 32'd0, alu_v, 1'b0, 0, 0, 20);
      exp_pc = exp_q.pop_front();
      checks++; if (pc !== exp_pc || tr_rfwe_cnt !== 1) begin
         failures++; $display("FAIL jalr_pc: got pc=%h rf_we_cnt=%0d want pc=%h rf_we_cnt=1", pc, tr_rfwe_cnt, exp_pc);
      end
      model_pc = exp_pc;
   endtask

   task automatic test_halt_illegal();
      apply_reset();
      run_instr(32'h0000_007F, 32'd0, 32'd0, 1'b0, 0, 0, 20);
      checks++; if (tr_halt_cyc !== 3 || tr_ret_cyc !== 0 || tr_rfwe_cnt !== 0) begin
         failures++; $display("FAIL illegal_halt: got halt_cyc=%0d ret=%0d rf_we=%0d want 3 0 0", tr_halt_cyc, tr_ret_cyc, tr_rfwe_cnt);
      end
      imem_ack = 1'b1; dmem_ack = 1'b1;
      repeat (4) @(negedge clk);
      checks++; if ({imem_req, halt, dmem_req, rf_we} !== 4'b0100 || pc !== RESET_PC) begin
         failures++; $display("FAIL illegal_hold: got req/halt/dreq/we=%b pc=%h want 0100 pc=%h", {imem_req, halt, dmem_req, rf_we}, pc, RESET_PC);
      end
      imem_ack = 1'b0; dmem_ack = 1'b0;
   endtask

   task automatic test_misaligned();
      apply_reset();
      run_instr(32'h0000_80E7, 32'd0, 32'h0000_0102, 1'b0, 0, 0, 20);
      checks++; if (tr_halt_cyc !== 4 || tr_ret_cyc !== 0 || tr_rfwe_cnt !== 0 || pc !== RESET_PC) begin
         failures++; $display("FAIL jalr_misaligned: got halt_cyc=%0d ret=%0d rf_we=%0d pc=%h want 4 0 0 %h", tr_halt_cyc, tr_ret_cyc, tr_rfwe_cnt, pc, RESET_PC);
      end
      apply_reset();
      run_instr(32'h0000_0363, 32'h0000_0006, 32'd0, 1'b1, 0, 0, 20);
      checks++; if (tr_halt_cyc !== 4 || tr_ret_cyc !== 0 || pc !== RESET_PC) begin
         failures++; $display("FAIL branch_misaligned: got halt_cyc=%0d ret=%0d pc=%h want 4 0 %h", tr_halt_cyc, tr_ret_cyc, pc, RESET_PC);
      end
   endtask

   task automatic test_timeout();
      logic ret_seen = 1'b0;
      apply_reset();
      run_instr(32'h0050_0093, 32'd0, 32'd0, 1'b0, 1000, 0, 40);
      checks++; if (tr_halt_cyc !== TMO + 1 || imem_req !== 1'b0) begin
         failures++; $display("FAIL fetch_timeout: got halt_cyc=%0d req=%b want %0d and 0", tr_halt_cyc, imem_req, TMO + 1);
      end
      imem_ack = 1'b1; imem_rdata = 32'h0050_0093;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (instret) ret_seen = 1'b1;
      end
      imem_ack = 1'b0;
      checks++; if (instr !== NOP || pc !== RESET_PC || halt !== 1'b1 || ret_seen !== 1'b0) begin
         failures++; $display("FAIL timeout_late_ack: got ir=%h pc=%h halt=%b ret=%b want %h %h 1 0", instr, pc, halt, ret_seen, NOP, RESET_PC);
      end
   endtask

   task automatic test_reset_mid_mem();
      logic [31:0] exp_pc;
      apply_reset();
      run_instr(32'h0050_0093, 32'd5, 32'd5, 1'b0, 0, 0, 20);
      run_instr(32'h0000_A183, 32'd0, 32'h0000_0300, 1'b0, 0, 1000, 6);
      checks++; if (dmem_req !== 1'b1 || tr_tmo !== 1'b1) begin
         failures++; $display("FAIL mid_mem_setup: got dreq=%b waiting=%b want 1 1", dmem_req, tr_tmo);
      end
      dmem_ack = 1'b1;
      reset_n  = 1'b0;
      #1;
      checks++; if (dmem_req !== 1'b0) begin failures++; $display("FAIL mid_mem_async_abort: got dreq=%b want 0", dmem_req); end
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      checks++; if (imem_req !== 1'b1 || imem_addr !== RESET_PC || dmem_req !== 1'b0) begin
         failures++; $display("FAIL mid_mem_restart: got req=%b addr=%h dreq=%b want 1 %h 0", imem_req, imem_addr, dmem_req, RESET_PC);
      end
      dmem_ack = 1'b0;
      model_pc = RESET_PC;
      exp_q.delete();
      exp_q.push_back(model_pc + 32'd4);
      run_instr(32'h0050_0093, 32'd5, 32'd5, 1'b0, 0, 0, 20);
      exp_pc = exp_q.pop_front();
      checks++; if (pc !== exp_pc || tr_ret_cyc !== 5) begin
         failures++; $display("FAIL mid_mem_refetch: got pc=%h ret=%0d want %h 5", pc, tr_ret_cyc, exp_pc);
      end
   endtask

   initial begin
      reset_n = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; imem_rdata = 32'd0;
      imm = 32'd0; alu_result = 32'd0; br_taken = 1'b0;
      test_reset();
      test_alu();
      test_load();
      test_store();
      test_jal();
      test_branch();
      test_jalr();
      test_halt_illegal();
      test_misaligned();
      test_timeout();
      test_reset_mid_mem();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL set the PC value loaded on reset.
REQ-002 Parameter TIMEOUT, default 16, SHALL set the maximum number of cycles to wait for a memory ack (range 1..65535).
REQ-003 Port clk, input, 1 bit, SHALL be the single clock; all state changes on its rising edge.
REQ-004 Port reset_n, input, 1 bit, SHALL be the reset; asynchronous, active-low.
REQ-005 Ports SHALL be, as name / direction / width / meaning:
- imem_req, out, 1: instruction fetch request.
- imem_addr, out, 32: fetch address; equals pc.
- imem_ack, in, 1: fetch done.
- imem_rdata, in, 32: fetched word.
- instr, out, 32: latched instruction register (IR).
- imm, in, 32: decoded immediate of IR.
- alu_result, in, 32: datapath ALU result.
- br_taken, in, 1: branch condition true.
- dmem_req, out, 1: data access request.
- dmem_we, out, 1: store (1) or load (0).
- dmem_addr, out, 32: data address.
- dmem_ack, in, 1: data access done.
- rf_we, out, 1: register-file write strobe.
- pc, out, 32: current PC.
- instret, out, 1: retire pulse.
- halt, out, 1: controller stopped.

Function
REQ-006 The FSM SHALL have exactly these states: FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-007 FETCH SHALL hold imem_req=1 with imem_addr=pc until imem_ack; on ack, IR SHALL be loaded with imem_rdata and the FSM SHALL enter DECODE; an ack in the first cycle of req (zero-wait) SHALL be accepted.
REQ-008 DECODE SHALL last 1 cycle; an opcode outside {LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP} SHALL go to HALT, otherwise to EXEC.
REQ-009 EXEC SHALL last 1 cycle and route as follows:
- LOAD/STORE: latch alu_result as dmem_addr, go to MEM.
- BRANCH: pc <= br_taken ? pc+imm : pc+4, pulse instret, go to FETCH.
- All other opcodes: go to WB.
REQ-010 MEM SHALL hold dmem_req=1 with stable dmem_addr and dmem_we (=STORE) until dmem_ack; on ack, a load SHALL go to WB, and a store SHALL set pc <= pc+4, pulse instret and go to FETCH.
REQ-011 WB SHALL assert rf_we for exactly 1 cycle, pulse instret and go to FETCH, with the next pc as follows:
- JAL: pc+imm.
- JALR: {alu_result[31:1],1'b0}.
- All other opcodes: pc+4.
REQ-012 A jump or taken-branch target with bit 1 set (misaligned) SHALL go to HALT without updating pc, without rf_we and without instret.
REQ-013 A wait counter SHALL count cycles spent in FETCH/MEM with req high and no ack, and SHALL clear on each state entry; reaching TIMEOUT SHALL go to HALT with req dropped.
REQ-014 imem_ack and dmem_ack SHALL be ignored whenever the matching req is low.
REQ-015 HALT SHALL hold halt=1, all req=0, rf_we=0 and pc frozen until reset.
REQ-016 imem_req and dmem_req SHALL never both be 1; instret SHALL be at most 1 per instruction.
REQ-017 Latency SHALL be, with zero-wait memory: ALU/JAL/JALR 4 cycles, branch 3, store 4, load 5.

Reset
REQ-018 While reset_n=0 the block SHALL hold: state=FETCH, pc=RESET_PC, IR=32'h0000_0013 (NOP), counter=0, and all of imem_req, dmem_req, dmem_we, rf_we, instret, halt = 0.
REQ-019 imem_req SHALL assert in the first cycle after reset_n rises.
REQ-020 Reset asserted mid-transaction SHALL abort the transaction immediately (req low asynchronously); a late ack SHALL be ignored.

Structure
REQ-021 The state enum, the opcode constants and the NOP constant SHALL live in the shared package riscv_pkg.
REQ-022 The timeout counter SHALL be the sub-module mem_wait_timer (inputs: clear, count; output: expired).

Verification
REQ-023 Reset, then imem returns 32'h00500093 (addi x1,x0,5) with 0 wait: imem_req in cycle 1, rf_we in cycle 4, pc=4, instret=1.
REQ-024 Load with 3 dmem wait states: dmem_req held 4 cycles with constant dmem_addr=alu_result, then rf_we 1 cycle later.
REQ-025 beq with br_taken=1 and imm=-8 at pc=0x20: pc=0x18 and rf_we never asserts.
REQ-026 imem_ack withheld for TIMEOUT=16 cycles: halt=1 and imem_req=0 from the next cycle; later acks are ignored.
REQ-027 Opcode 7'b1111111: HALT after DECODE; jalr with target 0x102: HALT and pc unchanged.
REQ-028 reset_n dropped during a MEM wait: dmem_req low at once; after release, fetch restarts at RESET_PC.
